gate_sweep_unit: RTL and testbench

GATE_SWEEP_UNIT -- requirements
Module: gate_sweep_unit

---
 rtl/gate_sweep_pkg.sv | 23 ++
 rtl/gate_eval.sv | 26 ++
 rtl/gate_sweep_unit.sv | 114 +++++++++++
 tb/tb_gate_sweep_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep unit: mode encodings, FSM states and
// the legal-mode check used when a sweep request arrives.
package gate_sweep_pkg;

    localparam logic [2:0] MODE_AND  = 3'b000;
    localparam logic [2:0] MODE_OR   = 3'b001;
    localparam logic [2:0] MODE_XOR  = 3'b010;
    localparam logic [2:0] MODE_NAND = 3'b011;
    localparam logic [2:0] MODE_NOR  = 3'b100;
    localparam logic [2:0] MODE_XNOR = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Encodings 110 and 111 have no gate function behind them.
    function automatic logic mode_legal(input logic [2:0] m);
        return (m <= MODE_XNOR);
    endfunction

endpackage

// File: rtl/gate_eval.sv
// Combinational N_IN-input gate: reduction AND/OR/XOR, optionally inverted.
module gate_eval
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] vec,
    input  logic [2:0]      mode,
    output logic            f
);

    // Select the reduction for the requested gate function.
    always_comb begin
        f = 1'b0;
        case (mode)
            MODE_AND:  f = &vec;
            MODE_OR:   f = |vec;
            MODE_XOR:  f = ^vec;
            MODE_NAND: f = ~&vec;
            MODE_NOR:  f = ~|vec;
            MODE_XNOR: f = ~^vec;
            default:   f = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_unit.sv
// Sweeps every input pattern through a configurable gate, holding each pattern
// for DWELL cycles, and captures the resulting truth table.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; illegal mode on start sets err
//   ST_SWEEP | stepping vec, evaluating y, loading truth at end of dwell
//   ST_DONE  | single-cycle done pulse, then back to idle
module gate_sweep_unit
    import gate_sweep_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int DWELL = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         mode,
    output logic [N_IN-1:0]    vec,
    output logic               y,
    output logic               busy,
    output logic               done,
    output logic [2**N_IN-1:0] truth,
    output logic               err
);

    localparam int CNT_W = $clog2(DWELL);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             reject;
    logic             last_dwell;
    logic             f;

    gate_eval #(.N_IN(N_IN)) u_gate_eval (
        .vec  (vec),
        .mode (mode_q),
        .f    (f)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and request qualification.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        reject     = 1'b0;
        last_dwell = (cnt_q == CNT_LAST);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (mode_legal(mode)) begin
                        accept  = 1'b1;
                        state_d = ST_SWEEP;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                if (last_dwell && (vec == VEC_LAST)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_SWEEP);
    assign done = (state_q == ST_DONE);

    // Sweep datapath: pattern stepping, dwell timing, result capture and err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_AND;
            cnt_q  <= '0;
            vec    <= '0;
            y      <= 1'b0;
            truth  <= '0;
            err    <= 1'b0;
        end else begin
            if (accept) begin
                mode_q <= mode;
                truth  <= '0;
                vec    <= '0;
                cnt_q  <= '0;
                err    <= 1'b0;
            end else if (reject) begin
                err <= 1'b1;
            end

            if (state_q == ST_SWEEP) begin
                y <= f;
                if (last_dwell) begin
                    // y already reflects the current vec: dwell is at least two cycles.
                    truth[vec] <= y;
                    cnt_q      <= '0;
                    if (vec != VEC_LAST) vec <= vec + 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Directed bench for gate_sweep_unit across three parameter sets.
module tb_gate_sweep_unit;

    logic clk;
    logic rst_n;

    logic        start2, start3, start4;
    logic [2:0]  mode2, mode3, mode4;
    logic [1:0]  vec2;
    logic [2:0]  vec3;
    logic [3:0]  vec4;
    logic        y2, y3, y4;
    logic        busy2, busy3, busy4;
    logic        done2, done3, done4;
    logic [3:0]  truth2;
    logic [7:0]  truth3;
    logic [15:0] truth4;
    logic        err2, err3, err4;

    int checks;
    int errors;

    gate_sweep_unit #(.N_IN(2), .DWELL(100)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .vec(vec2),
        .y(y2), .busy(busy2), .done(done2), .truth(truth2), .err(err2)
    );

    gate_sweep_unit #(.N_IN(3), .DWELL(100)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3), .vec(vec3),
        .y(y3), .busy(busy3), .done(done3), .truth(truth3), .err(err3)
    );

    gate_sweep_unit #(.N_IN(4), .DWELL(2)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .mode(mode4), .vec(vec4),
        .y(y4), .busy(busy4), .done(done4), .truth(truth4), .err(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        start2 = 1'b0; start3 = 1'b0; start4 = 1'b0;
        mode2 = 3'b000; mode3 = 3'b000; mode4 = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({vec2, y2, busy2, done2, truth2, err2} !== 10'b0) begin
            errors++;
            $display("FAIL reset_u2 got vec=%0d y=%b busy=%b done=%b truth=%b err=%b required all zero",
                     vec2, y2, busy2, done2, truth2, err2);
        end
        checks++;
        if ({busy3, done3, truth3, err3, busy4, done4, truth4, err4} !== 30'b0) begin
            errors++;
            $display("FAIL reset_u3u4 got truth3=%h truth4=%h required zero outputs", truth3, truth4);
        end
        #2 rst_n = 1'b1;
    endtask

    // N_IN=2 OR sweep: pattern stepping, y lag, latency and final table.
    task automatic test_or_sweep();
        int got;
        got = 0;
        @(posedge clk); #1 mode2 = 3'b001; start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        checks++;
        if (busy2 !== 1'b1 || vec2 !== 2'd0) begin
            errors++;
            $display("FAIL or_accept got busy=%b vec=%0d required busy=1 vec=0", busy2, vec2);
        end
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk); #1;
            if (n == 99)  begin checks++; if (vec2 !== 2'd0) begin errors++; $display("FAIL or_vec_99 got %0d required 0", vec2); end end
            if (n == 100) begin checks++; if (vec2 !== 2'd1 || y2 !== 1'b0) begin errors++; $display("FAIL or_step1 got vec=%0d y=%b required vec=1 y=0", vec2, y2); end end
            if (n == 101) begin checks++; if (y2 !== 1'b1) begin errors++; $display("FAIL or_y_lag got %b required 1", y2); end end
            if (n == 250) begin checks++; if (vec2 !== 2'd2) begin errors++; $display("FAIL or_vec_250 got %0d required 2", vec2); end end
            if (n == 399) begin checks++; if (vec2 !== 2'd3 || busy2 !== 1'b1) begin errors++; $display("FAIL or_vec_399 got vec=%0d busy=%b required vec=3 busy=1", vec2, busy2); end end
            if (done2 === 1'b1) begin got = n; break; end
        end
        // done is sampled by a downstream flop on the edge after it rises.
        checks++;
        if (got + 1 != 401) begin
            errors++;
            $display("FAIL or_latency got %0d required 401", got + 1);
        end
        checks++;
        if (truth2 !== 4'b1110 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL or_truth got truth=%b busy=%b required truth=1110 busy=0", truth2, busy2);
        end
        @(posedge clk); #1;
        checks++;
        if (done2 !== 1'b0 || busy2 !== 1'b0 || vec2 !== 2'd3 || truth2 !== 4'b1110) begin
            errors++;
            $display("FAIL or_hold got done=%b busy=%b vec=%0d truth=%b required 0 0 3 1110",
                     done2, busy2, vec2, truth2);
        end
    endtask

    task automatic test_xor3();
        int got;
        int busy_cnt;
        got = 0;
        busy_cnt = 0;
        @(posedge clk); #1 mode3 = 3'b010; start3 = 1'b1;
        @(posedge clk); #1 start3 = 1'b0;
        if (busy3 === 1'b1) busy_cnt++;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (busy3 === 1'b1) busy_cnt++;
            if (done3 === 1'b1) begin got = n; break; end
        end
        checks++;
        if (busy_cnt != 800) begin
            errors++;
            $display("FAIL xor3_busy_cycles got %0d required 800", busy_cnt);
        end
        checks++;
        if (got + 1 != 801) begin
            errors++;
            $display("FAIL xor3_latency got %0d required 801", got + 1);
        end
        checks++;
        if (truth3 !== 8'b10010110) begin
            errors++;
            $display("FAIL xor3_truth got %b required 10010110", truth3);
        end
    endtask

    task automatic test_nand4();
        int got;
        got = 0;
        @(posedge clk); #1 mode4 = 3'b011; start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (done4 === 1'b1) begin got = n; break; end
        end
        checks++;
        if (got + 1 != 33) begin
            errors++;
            $display("FAIL nand4_latency got %0d required 33", got + 1);
        end
        checks++;
        if (truth4 !== 16'h7FFF) begin
            errors++;
            $display("FAIL nand4_truth got %h required 7fff", truth4);
        end
    endtask

    // Illegal mode sets err; the following legal sweep is cut by an async reset.
    task automatic test_illegal_and_reset();
        @(posedge clk); #1 mode2 = 3'b111; start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        checks++;
        if (err2 !== 1'b1 || busy2 !== 1'b0 || truth2 !== 4'b1110) begin
            errors++;
            $display("FAIL illegal_mode got err=%b busy=%b truth=%b required 1 0 1110", err2, busy2, truth2);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_sticky got err=%b busy=%b required 1 0", err2, busy2);
        end
        mode2 = 3'b000; start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        checks++;
        if (err2 !== 1'b0 || busy2 !== 1'b1 || truth2 !== 4'b0000) begin
            errors++;
            $display("FAIL legal_clears_err got err=%b busy=%b truth=%b required 0 1 0000", err2, busy2, truth2);
        end
        repeat (250) @(posedge clk);
        #1;
        checks++;
        if (vec2 !== 2'd2 || busy2 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_vec got vec=%0d busy=%b required 2 1", vec2, busy2);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({vec2, y2, busy2, done2, truth2, err2} !== 10'b0) begin
            errors++;
            $display("FAIL async_reset got vec=%0d y=%b busy=%b done=%b truth=%b err=%b required all zero",
                     vec2, y2, busy2, done2, truth2, err2);
        end
        @(posedge clk); #3 rst_n = 1'b1;
    endtask

    task automatic test_after_reset_xnor();
        int got;
        got = 0;
        @(posedge clk); #1 mode2 = 3'b101; start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk); #1;
            if (done2 === 1'b1) begin got = n; break; end
        end
        checks++;
        if (got + 1 != 401 || truth2 !== 4'b1001) begin
            errors++;
            $display("FAIL xnor_after_reset got latency=%0d truth=%b required 401 1001", got + 1, truth2);
        end
    endtask

    // Restart and mode change mid-sweep, plus start during DONE, are ignored.
    task automatic test_back_to_back();
        int got;
        got = 0;
        @(posedge clk); #1 mode2 = 3'b000; start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk); #1;
            if (n == 50) begin mode2 = 3'b001; start2 = 1'b1; end
            if (n == 51) begin
                start2 = 1'b0;
                checks++;
                if (busy2 !== 1'b1 || vec2 !== 2'd0) begin
                    errors++;
                    $display("FAIL restart_ignored got busy=%b vec=%0d required 1 0", busy2, vec2);
                end
            end
            if (done2 === 1'b1) begin got = n; break; end
        end
        checks++;
        if (got + 1 != 401 || truth2 !== 4'b1000) begin
            errors++;
            $display("FAIL latched_mode got latency=%0d truth=%b required 401 1000", got + 1, truth2);
        end
        start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        checks++;
        if (busy2 !== 1'b0 || done2 !== 1'b0 || truth2 !== 4'b1000) begin
            errors++;
            $display("FAIL start_in_done got busy=%b done=%b truth=%b required 0 0 1000", busy2, done2, truth2);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_or_sweep();
        test_xor3();
        test_nand4();
        test_illegal_and_reset();
        test_after_reset_xnor();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
